// File: rtl/aes_round_ctrl_pkg.sv
// aes_round_ctrl_pkg
//   Shared AES constants, state/key types and GF(2^8) helpers for the
//   iterative cipher controller and its single-round datapath.
//   Byte ordering: state byte 4*j+i is row i, column j. Key words carry
//   row 0 in their MSB byte.
package aes_round_ctrl_pkg;

  localparam int Nb = 4;   // columns per state
  localparam int Nr = 10;  // rounds (AES-128)

  typedef logic [0:4*Nb-1][7:0]        state_t;
  typedef logic [0:Nb-1][31:0]         rkey_t;
  typedef logic [0:Nb*(Nr+1)-1][31:0]  kexp_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} ctrl_st_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box computed as affine(a^254): a^254 is the multiplicative inverse
  // for a != 0 and yields 0 for a == 0, which is exactly what AES wants.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x2, x3, x12, x15, x240, inv;
    x2   = gmul(a, a);
    x3   = gmul(x2, a);
    x12  = gmul(x3, x3);
    x12  = gmul(x12, x12);
    x15  = gmul(x12, x3);
    x240 = x15;
    for (int i = 0; i < 4; i++) x240 = gmul(x240, x240);
    inv  = gmul(gmul(x240, x12), x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // AddRoundKey: byte 4j+i takes row i (MSB byte = row 0) of key word j.
  function automatic state_t add_rkey(input state_t s, input rkey_t k);
    state_t r;
    for (int j = 0; j < Nb; j++)
      for (int i = 0; i < 4; i++)
        r[4*j+i] = s[4*j+i] ^ k[j][31-8*i -: 8];
    return r;
  endfunction

endpackage

// File: rtl/aes_round_ctrl_dp.sv
// aes_round_dp
//   Combinational single AES round: SubBytes, ShiftRows, MixColumns
//   (skipped when last=1), AddRoundKey.
//   Ports: state_in  - state entering the round
//          rkey      - Nb round key words
//          last      - final round, bypasses MixColumns
//          state_out - state leaving the round
module aes_round_dp
  import aes_round_ctrl_pkg::*;
(
  input  state_t state_in,
  input  rkey_t  rkey,
  input  logic   last,
  output state_t state_out
);

  state_t sb, sr, mc;

  always_comb begin
    sb = '0;
    sr = '0;
    mc = '0;
    for (int k = 0; k < 4*Nb; k++) sb[k] = sbox(state_in[k]);
    // row r rotates left by r columns
    for (int c = 0; c < Nb; c++)
      for (int r = 0; r < 4; r++)
        sr[4*c+r] = sb[4*((c+r)%Nb)+r];
    for (int c = 0; c < Nb; c++)
      for (int i = 0; i < 4; i++)
        mc[4*c+i] = xtime(sr[4*c+i]) ^ xtime(sr[4*c+(i+1)%4]) ^
                    sr[4*c+(i+1)%4] ^ sr[4*c+(i+2)%4] ^ sr[4*c+(i+3)%4];
  end

  assign state_out = add_rkey(last ? sr : mc, rkey);

endmodule

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl
//   Iterative AES cipher sequencer. Accepts one block per valid/ready
//   handshake, applies the round-0 key XOR on accept, then runs one round
//   per cycle through aes_round_dp for rounds 1..Nr and holds the result
//   until the output handshake.
//   Ports: clk/rst (async, active-high); in_valid/in_ready/in_data input
//   block; KExp expanded key (stable from accept to output handshake);
//   out_valid/out_ready/out_data ciphertext; busy (RUN or DONE); round.
//   Build option: AES_ABORT_EN adds input 'abort' which returns RUN/DONE
//   to IDLE on the next edge (wins over out_ready).
//   RND_W must satisfy 2**RND_W > Nr.
module aes_round_ctrl
  import aes_round_ctrl_pkg::*;
#(
  parameter int RND_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  state_t           in_data,
  input  kexp_t            KExp,
  output logic             out_valid,
  input  logic             out_ready,
  output state_t           out_data,
  output logic             busy,
  output logic [RND_W-1:0] round
`ifdef AES_ABORT_EN
  ,
  input  logic             abort
`endif
);

  localparam int KW = $clog2(Nb*(Nr+1)) + 1;

  ctrl_st_t         st_q, st_d;
  state_t           data_q, data_d, dp_out;
  logic [RND_W-1:0] rnd_q, rnd_d;
  logic [KW-1:0]    kbase;
  rkey_t            rk;
  logic             last;

  assign last  = (rnd_q == RND_W'(Nr));
  assign kbase = KW'(rnd_q) * KW'(Nb);
  assign rk    = KExp[kbase +: Nb];

  aes_round_dp u_dp (
    .state_in  (data_q),
    .rkey      (rk),
    .last      (last),
    .state_out (dp_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= IDLE;
      rnd_q  <= '0;
      data_q <= '0;
    end else begin
      st_q   <= st_d;
      rnd_q  <= rnd_d;
      data_q <= data_d;
    end
  end

  // Handshake outputs depend on st_q only, so there is no path from
  // in_valid/out_ready to in_ready/out_valid.
  always_comb begin
    st_d      = st_q;
    rnd_d     = rnd_q;
    data_d    = data_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (st_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d = add_rkey(in_data, KExp[0 +: Nb]);
          rnd_d  = RND_W'(1);
          st_d   = RUN;
        end
      end
      RUN: begin
        data_d = dp_out;
        if (last) st_d = DONE;   // round parks at Nr
        else      rnd_d = rnd_q + 1'b1;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          st_d  = IDLE;
          rnd_d = '0;
        end
      end
      default: st_d = IDLE;
    endcase
`ifdef AES_ABORT_EN
    if (abort && st_q != IDLE) begin
      st_d   = IDLE;
      rnd_d  = '0;
      data_d = data_q;
    end
`endif
  end

  assign out_data = data_q;
  assign busy     = (st_q != IDLE);
  assign round    = rnd_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
`timescale 1ns/1ps
module tb_aes_round_ctrl;
  import aes_round_ctrl_pkg::*;

  localparam int RND_W = 4;

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  vec_t  vecs [2];
  kexp_t kx   [2];
  logic [7:0] sb [256];

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, busy;
  state_t in_data, out_data;
  kexp_t  kexp;
  logic [RND_W-1:0] round;
`ifdef AES_ABORT_EN
  logic abort;
`endif

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int n_out    = 0;
  int n_exp_out = 0;
  logic [127:0] cur_ct;
  logic [127:0] exp_q [$];
  int lat_q [$];
  int acc_hist [$];
  logic prev_ov = 1'b0;

  aes_round_ctrl #(.RND_W(RND_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .KExp      (kexp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .round     (round)
`ifdef AES_ABORT_EN
    ,
    .abort     (abort)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit reached, checks %0d", n_checks);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic chki(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b};
    return t[15-n -: 8];
  endfunction

  // S-box via exp/log tables over generator 3
  task automatic init_sbox();
    logic [7:0] ex [256];
    int lg [256];
    logic [7:0] p, inv;
    p = 8'h01;
    for (int i = 0; i < 255; i++) begin
      ex[i] = p;
      lg[p] = i;
      p = p ^ xt(p);
    end
    for (int x = 0; x < 256; x++) begin
      inv = (x == 0) ? 8'h00 : ex[(255 - lg[x]) % 255];
      sb[x] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic kexp_t expand(input logic [127:0] key);
    logic [31:0] w [Nb*(Nr+1)];
    logic [31:0] t;
    logic [7:0]  rc;
    kexp_t k;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < Nb*(Nr+1); i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < Nb*(Nr+1); i++) k[i] = w[i];
    return k;
  endfunction

  // scoreboard: push on accept, pop on output handshake
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(cur_ct);
        lat_q.push_back(cyc);
        acc_hist.push_back(cyc);
      end
      if (out_valid && !prev_ov) begin
        if (lat_q.size() == 0) chki("latency_noacc", 0, 1);
        else chki("latency", 32'(cyc - lat_q.pop_front()), 32'(Nr + 1));
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) chki("ct_unexpected", 1, 0);
        else chk("ct", out_data, exp_q.pop_front());
      end
      prev_ov = out_valid;
    end
  end

  // call at posedge+2; returns at posedge+2 after the accepting edge
  task automatic drive(input int v);
    int i = 0;
    kexp = kx[v]; in_data = vecs[v].pt; cur_ct = vecs[v].ct; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && i < 40) begin @(negedge clk); i++; end
    chki("accept", 32'(in_ready), 1);
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  // returns at a negedge with out_valid high (or bound expired)
  task automatic wait_ov(input string nm);
    int i = 0;
    @(negedge clk);
    while (!out_valid && i < 40) begin @(negedge clk); i++; end
    chki(nm, 32'(out_valid), 1);
  endtask

  task automatic wait_round(input int r);
    int i = 0;
    @(negedge clk);
    while (round != RND_W'(r) && i < 40) begin @(negedge clk); i++; end
    chki("wait_round", 32'(round), 32'(r));
  endtask

  initial begin
    int n0;
    init_sbox();
    vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3243f6a8885a308d313198a2e0370734,
                128'h3925841d02dc09fbdc118597196a0b32};
    vecs[1] = '{128'h000102030405060708090a0b0c0d0e0f,
                128'h00112233445566778899aabbccddeeff,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    for (int v = 0; v < 2; v++) kx[v] = expand(vecs[v].key);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; kexp = '0; cur_ct = '0;
`ifdef AES_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chki("rst_in_ready", 32'(in_ready), 1);
    chki("rst_out_valid", 32'(out_valid), 0);
    chki("rst_busy", 32'(busy), 0);
    chki("rst_round", 32'(round), 0);
    chk("rst_out_data", out_data, '0);
    @(posedge clk); #2;
    rst = 1'b0;

    // FIPS-197 vectors, out_ready held high: out_valid lasts one cycle
    out_ready = 1'b1;
    for (int v = 0; v < 2; v++) begin
      drive(v);
      n_exp_out++;
      @(negedge clk);
      chki("run_round1", 32'(round), 1);
      chki("run_busy", 32'(busy), 1);
      chki("run_in_ready", 32'(in_ready), 0);
      wait_ov("out_valid_seen");
      chki("done_round", 32'(round), 32'(Nr));
      chki("done_in_ready", 32'(in_ready), 0);
      @(negedge clk);
      chki("ov_one_cycle", 32'(out_valid), 0);
      chki("idle_round", 32'(round), 0);
      chki("idle_busy", 32'(busy), 0);
      chki("idle_in_ready", 32'(in_ready), 1);
      @(posedge clk); #2;
    end

    // backpressure: 20 cycles in DONE with in_valid pulses
    out_ready = 1'b0;
    drive(0);
    n_exp_out++;
    wait_ov("bp_out_valid");
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #2;
      in_valid = c[0];
      in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(negedge clk);
      chk("bp_data", out_data, vecs[0].ct);
      chki("bp_out_valid", 32'(out_valid), 1);
      chki("bp_in_ready", 32'(in_ready), 0);
    end
    @(posedge clk); #2;
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chki("bp_release_idle", 32'(in_ready), 1);
    @(posedge clk); #2;

    // back-to-back: in_valid and out_ready high
    n0 = acc_hist.size();
    kexp = kx[0]; in_data = vecs[0].pt; cur_ct = vecs[0].ct; in_valid = 1'b1;
    n_exp_out += 2;
    wait_ov("b2b_ov0");
    @(posedge clk); #2;
    kexp = kx[1]; in_data = vecs[1].pt; cur_ct = vecs[1].ct;
    @(negedge clk);
    @(posedge clk); #2;
    in_valid = 1'b0;
    wait_ov("b2b_ov1");
    if (acc_hist.size() >= n0 + 2) chki("b2b_gap", 32'(acc_hist[n0+1] - acc_hist[n0]), 32'(Nr + 2));
    else chki("b2b_accepts", 32'(acc_hist.size() - n0), 2);
    @(posedge clk); #2;

    // reset mid-block at round 5
    drive(0);
    wait_round(5);
    #1 rst = 1'b1;
    #1;
    chki("mrst_in_ready", 32'(in_ready), 1);
    chki("mrst_out_valid", 32'(out_valid), 0);
    chki("mrst_busy", 32'(busy), 0);
    chki("mrst_round", 32'(round), 0);
    chk("mrst_out_data", out_data, '0);
    exp_q.delete(); lat_q.delete();
    @(posedge clk); #2;
    rst = 1'b0;
    drive(1);
    n_exp_out++;
    wait_ov("post_rst_ov");
    @(posedge clk); #2;

`ifdef AES_ABORT_EN
    drive(0);
    wait_round(3);
    #1 abort = 1'b1;
    @(posedge clk); #2;
    abort = 1'b0;
    @(negedge clk);
    chki("abort_in_ready", 32'(in_ready), 1);
    chki("abort_out_valid", 32'(out_valid), 0);
    chki("abort_round", 32'(round), 0);
    chki("abort_busy", 32'(busy), 0);
    exp_q.delete(); lat_q.delete();
    begin
      int seen = 0;
      for (int c = 0; c < 15; c++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      chki("abort_no_ov", 32'(seen), 0);
    end
    @(posedge clk); #2;
    drive(1);
    n_exp_out++;
    wait_ov("post_abort_ov");
    @(posedge clk); #2;
`endif

    repeat (2) @(negedge clk);
    chki("queue_empty", 32'(exp_q.size()), 0);
    chki("output_count", 32'(n_out), 32'(n_exp_out));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
